// File: rtl/ctrl_pkg.sv
// Shared control-path definitions: fetch FSM encoding, opcode constants
// used by both the fetch sequencer and the decoder, ALU/branch encodings.
package ctrl_pkg;

    typedef enum logic [1:0] {
        RESET     = 2'd0,
        FETCH     = 2'd1,
        FETCH_IMM = 2'd2,
        S_INTR    = 2'd3
    } fetch_state_t;

    // Opcodes shared with the decoder
    localparam logic [3:0] OPC_IMM    = 4'd12;
    localparam logic [3:0] OPC_JMPGRP = 4'd11;
    localparam logic [1:0] RA_RTI     = 2'd3;

    // ALU operation select
    localparam logic [2:0] ALU_NOP = 3'd0;
    localparam logic [2:0] ALU_ADD = 3'd1;
    localparam logic [2:0] ALU_SUB = 3'd2;
    localparam logic [2:0] ALU_AND = 3'd3;
    localparam logic [2:0] ALU_OR  = 3'd4;
    localparam logic [2:0] ALU_NOT = 3'd5;
    localparam logic [2:0] ALU_SHL = 3'd6;
    localparam logic [2:0] ALU_SHR = 3'd7;

    // Branch type select
    localparam logic [1:0] BR_NONE = 2'd0;
    localparam logic [1:0] BR_Z    = 2'd1;
    localparam logic [1:0] BR_C    = 2'd2;
    localparam logic [1:0] BR_ALWS = 2'd3;

    // Width needed to index n items, never less than one bit
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bus between the fetch sequencer and its surroundings: hazard unit,
// IF/ID instruction fields, IRQ lines, and the PC / pipeline-register controls.
interface fetch_sequencer_if
    import ctrl_pkg::*;
#(
    parameter int N_IRQ = 4
) ();

    localparam int IDX_W = clog2_min1(N_IRQ);

    logic             stall;
    logic [3:0]       opcode;
    logic [1:0]       ra;
    logic [N_IRQ-1:0] irq;

    logic             PC_Write_En;
    logic             IF_ID_Write_En;
    logic             Inject_Bubble;
    logic             Inject_Int;
    logic [IDX_W-1:0] int_vec_idx;
    logic             int_active;
    logic             int_en;

    // Sequencer side
    modport master (
        input  stall, opcode, ra, irq,
        output PC_Write_En, IF_ID_Write_En, Inject_Bubble, Inject_Int,
               int_vec_idx, int_active, int_en
    );

    // Pipeline / environment side
    modport slave (
        output stall, opcode, ra, irq,
        input  PC_Write_En, IF_ID_Write_En, Inject_Bubble, Inject_Int,
               int_vec_idx, int_active, int_en
    );

endinterface

// File: rtl/irq_pending_arb.sv
// Interrupt pending register: rising-edge capture of each IRQ line, a
// clear port for the request being serviced (a new edge wins over a clear),
// and a fixed-priority pick where bit 0 is the most urgent.
module irq_pending_arb
    import ctrl_pkg::*;
#(
    parameter int N_IRQ = 4,
    parameter int IDX_W = clog2_min1(N_IRQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] irq,
    input  logic             clr_en,
    input  logic [IDX_W-1:0] clr_idx,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    logic [N_IRQ-1:0] irq_q;
    logic [N_IRQ-1:0] pending;
    logic [N_IRQ-1:0] rise;
    logic [N_IRQ-1:0] clr_mask;

    // A held-high line produces exactly one rise
    assign rise = irq & ~irq_q;

    // One-hot mask of the request being taken this cycle
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        clr_mask = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            clr_mask[i] = clr_en && (clr_idx == IDX_W'(i));
        end
    end

    // Edge history and pending bits; the OR after the clear lets a new edge win
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the pending bits are control state, so they are reset; a pending IRQ must not survive reset.
        if (rst) begin
            irq_q   <= '0;
            pending <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            irq_q   <= irq;
            pending <= (pending & ~clr_mask) | rise;
        end
    end

    // Fixed-priority encoder: scanning downward leaves the lowest set index
    always_comb begin
        valid = |pending;
        idx   = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (pending[i]) idx = IDX_W'(i);
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-control FSM: reset bubble, multi-word immediate fetch, hazard
// stalls and prioritised interrupt entry with a global enable re-armed by RTI.
module fetch_sequencer
    import ctrl_pkg::*;
#(
    parameter int         N_IRQ      = 4,
    parameter int         IMM_WORDS  = 1,
    parameter int         INT_CYCLES = 1,
    parameter logic [3:0] IMM_OPCODE = OPC_IMM,
    parameter logic [3:0] RTI_OPCODE = OPC_JMPGRP,
    parameter logic [1:0] RTI_RA     = RA_RTI
) (
    input  logic               clk,
    input  logic               rst,
    fetch_sequencer_if.master  bus
);

    localparam int IDX_W   = clog2_min1(N_IRQ);
    localparam int CNT_MAX = (IMM_WORDS > INT_CYCLES) ? IMM_WORDS : INT_CYCLES;
    localparam int CNT_W   = clog2_min1(CNT_MAX);

    localparam logic [CNT_W-1:0] IMM_CNT_INIT = CNT_W'(IMM_WORDS - 1);
    localparam logic [CNT_W-1:0] INT_CNT_INIT = CNT_W'(INT_CYCLES - 1);

    fetch_state_t     state;
    logic [CNT_W-1:0] cnt;
    logic             int_en_r;
    logic [IDX_W-1:0] vec_idx_r;

    logic             arb_valid;
    logic [IDX_W-1:0] arb_idx;
    logic             take;
    logic             is_imm;
    logic             is_rti;

    assign is_imm = (bus.opcode == IMM_OPCODE);
    assign is_rti = (bus.opcode == RTI_OPCODE) && (bus.ra == RTI_RA);

    // An interrupt is entered only from an unstalled FETCH with interrupts enabled
    assign take = (state == FETCH) && !bus.stall && int_en_r && arb_valid;

    irq_pending_arb #(
        .N_IRQ (N_IRQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .irq     (bus.irq),
        .clr_en  (take),
        .clr_idx (arb_idx),
        .valid   (arb_valid),
        .idx     (arb_idx)
    );

    // State, beat counter, interrupt enable and serviced vector index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RESET;
            cnt       <= '0;
            int_en_r  <= 1'b1;
            vec_idx_r <= '0;
        end else begin
            case (state)
                RESET: state <= FETCH;
                FETCH: begin
                    if (!bus.stall) begin
                        if (int_en_r && arb_valid) begin
                            vec_idx_r <= arb_idx;
                            int_en_r  <= 1'b0;
                            cnt       <= INT_CNT_INIT;
                            state     <= S_INTR;
                        end else if (is_imm) begin
                            cnt   <= IMM_CNT_INIT;
                            state <= FETCH_IMM;
                        end else if (is_rti) begin
                            int_en_r <= 1'b1;
                        end
                    end
                end
                FETCH_IMM, S_INTR: begin
                    if (!bus.stall) begin
                        if (cnt == '0) state <= FETCH;
                        else           cnt   <= cnt - 1'b1;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

    // Per-cycle pipeline controls decoded from state and the current inputs
    always_comb begin
        bus.PC_Write_En    = 1'b1;
        bus.IF_ID_Write_En = 1'b1;
        bus.Inject_Bubble  = 1'b0;
        bus.Inject_Int     = 1'b0;
        bus.int_active     = 1'b0;
        case (state)
            RESET: bus.Inject_Bubble = 1'b1;
            FETCH: begin
                if (bus.stall) begin
                    bus.PC_Write_En    = 1'b0;
                    bus.IF_ID_Write_En = 1'b0;
                end else if (take) begin
                    bus.Inject_Int = 1'b1;
                end else if (is_imm) begin
                    bus.IF_ID_Write_En = 1'b0;
                    bus.Inject_Bubble  = 1'b1;
                end
            end
            FETCH_IMM: begin
                if (cnt != '0) begin
                    bus.IF_ID_Write_En = 1'b0;
                    bus.Inject_Bubble  = 1'b1;
                end
                if (bus.stall) begin
                    bus.PC_Write_En    = 1'b0;
                    bus.IF_ID_Write_En = 1'b0;
                end
            end
            S_INTR: begin
                bus.int_active = 1'b1;
                if (bus.stall) begin
                    bus.PC_Write_En    = 1'b0;
                    bus.IF_ID_Write_En = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign bus.int_vec_idx = vec_idx_r;
    assign bus.int_en      = int_en_r;

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Parametrised successor to the fetch-control half of the pipelined control unit. It owns the fetch FSM: reset bubble, multi-word (immediate) instruction fetch, hazard stalls, and a multi-source prioritised interrupt entry with a global enable that is re-armed by RTI. Sits between the hazard unit, external IRQ lines and the PC mux / IF-ID register; the combinational decoder stays a separate block.

Parameters:
N_IRQ, 4, number of interrupt request lines (>=1); bit 0 has the highest priority.
IMM_WORDS, 1, extra fetch cycles consumed by an immediate-class opcode (>=1).
INT_CYCLES, 1, cycles spent in interrupt-entry state, i.e. stack push beats (>=1).
IMM_OPCODE, 4'd12, opcode that carries trailing immediate words.
RTI_OPCODE, 4'd11, opcode group containing RTI.
RTI_RA, 2'd3, ra value selecting RTI within RTI_OPCODE.
IDX_W, max(1,clog2(N_IRQ)), derived width of the vector index.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
stall  in  1  hazard-unit freeze request.
opcode  in  4  opcode of the instruction in IF/ID.
ra  in  2  ra field of the instruction in IF/ID.
irq  in  N_IRQ  interrupt request lines, synchronous to clk.
PC_Write_En  out  1  PC register enable.
IF_ID_Write_En  out  1  IF/ID register enable.
Inject_Bubble  out  1  force NOP into ID/EX.
Inject_Int  out  1  PC mux selects the interrupt vector.
int_vec_idx  out  IDX_W  index of the interrupt being serviced (registered).
int_active  out  1  high while in S_INTR.
int_en  out  1  global interrupt enable flag.

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-high. While rst=1: state=RESET, pending=0, irq_q=0, int_en=1, int_vec_idx=0, counters=0.
- Default outputs each cycle: PC_Write_En=1, IF_ID_Write_En=1, Inject_Bubble=0, Inject_Int=0, int_active=0.
- RESET: Inject_Bubble=1 (the default enables stay 1) -> FETCH. Exactly one cycle after rst deasserts.
- FETCH priority, highest first:
  1. stall=1: PC_Write_En=0, IF_ID_Write_En=0, stay in FETCH, no IRQ taken.
  2. int_en=1 and pending!=0: Inject_Int=1; latch int_vec_idx = lowest set pending bit; clear that bit; int_en<=0; cnt<=INT_CYCLES-1 -> S_INTR.
  3. opcode==IMM_OPCODE: IF_ID_Write_En=0, Inject_Bubble=1, cnt<=IMM_WORDS-1 -> FETCH_IMM.
  4. opcode==RTI_OPCODE and ra==RTI_RA: int_en<=1, stay in FETCH.
  5. Otherwise stay in FETCH.
- FETCH_IMM: while cnt!=0, IF_ID_Write_En=0, Inject_Bubble=1, cnt decrements. When cnt==0, default outputs apply -> FETCH. Total length is IMM_WORDS cycles; IMM_WORDS=1 gives a single default cycle.
- S_INTR: int_active=1, otherwise default outputs. When cnt==0 -> FETCH, else cnt decrements. Length is INT_CYCLES cycles.
- Stall in FETCH_IMM/S_INTR: PC_Write_En=0, IF_ID_Write_En=0, cnt and state frozen; Inject_Bubble keeps its state value.
- Pending logic:
  - irq_q <= irq every cycle.
  - Rising edge (irq & ~irq_q) sets the pending bit, and does so in all states and regardless of int_en.
  - Same-cycle set and clear of one bit: set wins.
  - A held-high line never retriggers.
- Unknown state encoding -> FETCH with default outputs.
- rst mid FETCH_IMM/S_INTR aborts immediately to RESET; pending IRQs are lost.

Decomposition:
- Shared package ctrl_pkg:
  - state encoding RESET/FETCH/FETCH_IMM/S_INTR (2 bits);
  - opcode constants OPC_IMM=12, OPC_JMPGRP=11, RA_RTI=3, shared with the decoder;
  - ALU op and branch-type localparams, moved there from the decoder.
- One sub-module, irq_pending_arb (N_IRQ): edge detect, pending register, set-wins clear, fixed-priority encoder giving valid+idx.

Test Plan:
- Reset: rst=1 for 3 cycles, then 0 -> first cycle Inject_Bubble=1, int_en=1, then FETCH with all enables 1.
- Immediate: IMM_WORDS=3, opcode=12 in FETCH -> IF_ID_Write_En=0 / Inject_Bubble=1 for 3 cycles, 4th cycle defaults, back to FETCH.
- Priority: irq=4'b1010 pulsed together, RTI between services -> first take idx=1 with Inject_Int=1 for one cycle; after RTI (opcode=11, ra=3) next take idx=3.
- Masking: IRQ edge while int_en=0 -> stays pending, no Inject_Int until RTI; taken the cycle after int_en returns to 1.
- Stall: stall=1 during FETCH with pending IRQ, and mid FETCH_IMM with cnt=1 -> PC/IF_ID enables 0, no take, cnt held; completes normally after stall drops.
- Edge cases: irq[0] held high for 20 cycles -> exactly one service; rst asserted in S_INTR with INT_CYCLES=4 -> immediate RESET, pending=0.
